// File: rtl/peri_bus_bridge_if.sv
// Bus bundle between the core peripheral port, the bridge and its N_SLAVES devices.
// master: the core plus slave devices (environment side); slave: the bridge itself.
interface peri_bus_bridge_if #(
    parameter int N_SLAVES = 4
);
    // Master side of the peripheral port
    logic [31:0]             peri_addr;
    logic [31:0]             peri_wdata;
    logic [3:0]              peri_wmask;
    logic                    peri_wen;
    logic                    peri_ren;
    logic [31:0]             peri_rdata;
    logic                    peri_ready;
    logic                    peri_err;

    // Shared slave bus with one-hot select
    logic [N_SLAVES-1:0]     s_sel;
    logic [31:0]             s_addr;
    logic [31:0]             s_wdata;
    logic [3:0]              s_wstrb;
    logic                    s_wen;
    logic                    s_ren;
    logic [32*N_SLAVES-1:0]  s_rdata;
    logic [N_SLAVES-1:0]     s_ready;

    // Current bridge FSM state (0 IDLE, 1 ACCESS, 2 RESP) for observation
    logic [1:0]              dbg_state;

    // Handshake: a request (peri_wen or peri_ren) is held until the one-cycle
    // peri_ready pulse; peri_rdata/peri_err are valid only in that cycle. Each
    // slave answers its strobe with exactly one s_ready cycle while selected.
    modport master (
        output peri_addr, peri_wdata, peri_wmask, peri_wen, peri_ren,
        output s_rdata, s_ready,
        input  peri_rdata, peri_ready, peri_err,
        input  s_sel, s_addr, s_wdata, s_wstrb, s_wen, s_ren, dbg_state
    );

    modport slave (
        input  peri_addr, peri_wdata, peri_wmask, peri_wen, peri_ren,
        input  s_rdata, s_ready,
        output peri_rdata, peri_ready, peri_err,
        output s_sel, s_addr, s_wdata, s_wstrb, s_wen, s_ren, dbg_state
    );
endinterface

// File: rtl/peri_bus_bridge.sv
// Peripheral bridge: one master port to N_SLAVES region-decoded slaves with wait states,
// timeout and bus-error response. Optional error-address capture: PERI_ERR_CAPTURE_EN.
module peri_bus_bridge #(
    parameter int          N_SLAVES    = 4,
    parameter int          BASE_REGION = 3,
    parameter int          TIMEOUT     = 255,
    parameter logic [31:0] ERR_RDATA   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
`ifdef PERI_ERR_CAPTURE_EN
    output logic [31:0]        err_addr,
    input  logic               err_clr,
`endif
    peri_bus_bridge_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0]  BASE4       = 4'(BASE_REGION);
    localparam logic [4:0]  NSLV5       = 5'(N_SLAVES);
    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    state_t       state_q, state_d;
    logic [27:0]  addr_q, addr_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [3:0]   wmask_q, wmask_d;
    logic         write_q, write_d;
    logic [3:0]   idx_q, idx_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         err_q, err_d;

    logic [3:0]   req_idx;
    logic [31:0]  sel_rdata;
    logic         sel_ready;

    // Region wraps in 4 bits, so regions below BASE_REGION land on large indices.
    assign req_idx = bus.peri_addr[31:28] - BASE4;

    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (idx_q == 4'(i)) begin
                sel_rdata = bus.s_rdata[i*32 +: 32];
                sel_ready = bus.s_ready[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        write_d = write_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.peri_wen || bus.peri_ren) begin
                    addr_d  = bus.peri_addr[27:0];
                    wdata_d = bus.peri_wdata;
                    wmask_d = bus.peri_wmask;
                    write_d = bus.peri_wen;
                    idx_d   = req_idx;
                    err_d   = 1'b0;
                    // Write wins over a simultaneous read; an empty mask makes it a no-op.
                    if (bus.peri_wen && (bus.peri_wmask == 4'b0000)) begin
                        state_d = RESP;
                    end else if ({1'b0, req_idx} < NSLV5) begin
                        state_d = ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = ERR_RDATA;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 16'd1;
                if (sel_ready) begin
                    if (!write_q) begin
                        rdata_d = sel_rdata;
                    end
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_d == TIMEOUT_CNT) begin
                    err_d   = 1'b1;
                    rdata_d = ERR_RDATA;
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Slave strobes exist only in ACCESS; address/data buses hold the last latched values.
    always_comb begin
        bus.s_sel = '0;
        if (state_q == ACCESS) begin
            for (int i = 0; i < N_SLAVES; i++) begin
                bus.s_sel[i] = (idx_q == 4'(i));
            end
        end
    end

    assign bus.s_wen      = (state_q == ACCESS) && write_q;
    assign bus.s_ren      = (state_q == ACCESS) && !write_q;
    assign bus.s_addr     = {4'h0, addr_q};
    assign bus.s_wdata    = wdata_q;
    assign bus.s_wstrb    = wmask_q;
    assign bus.peri_ready = (state_q == RESP);
    assign bus.peri_err   = (state_q == RESP) && err_q;
    assign bus.peri_rdata = rdata_q;
    assign bus.dbg_state  = state_q;

`ifdef PERI_ERR_CAPTURE_EN
    logic         err_event;
    logic [31:0]  err_src;
    logic         err_valid_q;
    logic [31:0]  err_addr_q;

    // A timeout rebuilds the full address from the latched slave index.
    assign err_event = (state_q != RESP) && (state_d == RESP) && err_d;
    assign err_src   = (state_q == IDLE) ? bus.peri_addr : {idx_q + BASE4, addr_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else if (err_event && (!err_valid_q || err_clr)) begin
            err_valid_q <= 1'b1;
            err_addr_q  <= err_src;
        end else if (err_clr) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end
    end

    assign err_addr = err_addr_q;
`endif

endmodule
